retention_noise_injector: RTL

- Parametrised successor to the fixed 4-level retention distortion stage in the flash channel model.
- Subtracts a per-level random retention shift from each cell voltage. The shift is drawn from a per-level noise table that runtime configuration can write, addressed by an internal 32-bit LFSR.
- Adds valid/ready flow control, saturating arithmetic, seed reload with pipeline drain, and a saturation counter.
- Sits between the programming-noise stage and the read/detection stage.

---
 rtl/retention_noise_injector.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/retention_noise_injector.sv
// Retention distortion stage: subtracts a per-level random retention shift,
// drawn from a runtime-writable noise table addressed by a 32-bit Galois LFSR,
// from each cell voltage. Two-stage valid/ready pipeline with saturating
// arithmetic, a saturation counter, and a seed reload that drains the pipe first.
module retention_noise_injector #(
  parameter int          VW           = 16,
  parameter int          NW           = 16,
  parameter int          LEVEL_BITS   = 2,
  parameter int          LUT_AW       = 13,
  parameter int          ERASE_BYPASS = 1,
  parameter logic [31:0] SEED         = 32'h3721AD74
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cfg_we,
  input  logic [LEVEL_BITS-1:0] cfg_level,
  input  logic [LUT_AW-1:0]     cfg_addr,
  input  logic [NW-1:0]         cfg_data,
  input  logic                  seed_load,
  input  logic [31:0]           seed_value,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [VW-1:0]         in_voltage,
  input  logic [LEVEL_BITS-1:0] in_level,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [VW-1:0]         out_voltage,
  output logic [LEVEL_BITS-1:0] out_level,
  output logic                  out_sat,
  output logic [15:0]           sat_count,
  output logic                  busy
);

  localparam int          DEPTH = 2 ** (LEVEL_BITS + LUT_AW);
  localparam logic [31:0] TAPS  = 32'h80200003;

  typedef enum logic [1:0] {
    ST_SEED,
    ST_RUN,
    ST_DRAIN
  } state_t;

  state_t              state;
  state_t              state_nx;
  logic [31:0]         lfsr;
  logic [31:0]         seed_hold;
  logic                latch_seed;
  logic                advance;
  logic                accept;
  logic                pipe_empty;
  logic                rd_en;

  logic [NW-1:0]       mem [DEPTH];
  logic [NW-1:0]       rd_data;

  logic                s1_valid;
  logic [VW-1:0]       s1_voltage;
  logic [LEVEL_BITS-1:0] s1_level;

  logic [VW-1:0]       noise;
  logic                sat;
  logic [VW-1:0]       result;

  // Pipeline flow control: every stage moves together whenever the output
  // register is empty or being consumed.
  assign advance    = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign pipe_empty = !s1_valid && !out_valid;
  // Level 0 (erased) cells take no noise, so their table is never read.
  assign rd_en      = advance && !((ERASE_BYPASS != 0) && (in_level == '0));

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would create order-dependent races.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_SEED;
    else       state <= state_nx;
  end

  // Next-state and handshake decode.
  // NOTE: every output of this block gets a default first, so no path leaves a
  // value unassigned and no latch is inferred.
  always_comb begin
    state_nx   = state;
    in_ready   = 1'b0;
    busy       = 1'b1;
    latch_seed = 1'b0;
    unique case (state)
      ST_SEED: state_nx = ST_RUN;
      ST_RUN: begin
        busy     = 1'b0;
        in_ready = advance;
        if (seed_load) begin
          latch_seed = 1'b1;
          state_nx   = ST_DRAIN;
        end
      end
      ST_DRAIN: if (pipe_empty) state_nx = ST_RUN;
      default:  state_nx = ST_SEED;
    endcase
  end

  // Pending seed captured on a reload request; zero would lock the LFSR, so it
  // is replaced by the default seed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)           seed_hold <= SEED;
    else if (latch_seed) seed_hold <= (seed_value == 32'd0) ? SEED : seed_value;
  end

  // LFSR: seeded on reset exit and after a drain, otherwise steps once per
  // accepted sample so the noise sequence depends only on sample order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                lfsr <= '0;
    else if (state == ST_SEED)                lfsr <= SEED;
    else if (state == ST_DRAIN && pipe_empty) lfsr <= seed_hold;
    else if (accept)                          lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : 32'd0);
  end

  // Noise table write port.
  // NOTE: the table is a RAM and deliberately has no reset; its contents
  // survive reset and are undefined until written.
  always_ff @(posedge clk) begin
    if (cfg_we) mem[{cfg_level, cfg_addr}] <= cfg_data;
  end

  // Noise table read port (stage 1); a same-entry write returns the old data.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[{in_level, lfsr[LUT_AW-1:0]}];
  end

  // Stage 1: voltage and level registered alongside the table read.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid   <= 1'b0;
      s1_voltage <= '0;
      s1_level   <= '0;
    end else if (advance) begin
      s1_valid   <= accept;
      s1_voltage <= in_voltage;
      s1_level   <= in_level;
    end
  end

  // Saturating subtraction of the zero-extended noise sample.
  always_comb begin
    noise = VW'(rd_data);
    if ((ERASE_BYPASS != 0) && (s1_level == '0)) noise = '0;
    sat    = s1_voltage < noise;
    result = sat ? '0 : (s1_voltage - noise);
  end

  // Stage 2: output register and saturation counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_voltage <= '0;
      out_level   <= '0;
      out_sat     <= 1'b0;
      sat_count   <= '0;
    end else if (advance) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_voltage <= result;
        out_level   <= s1_level;
        out_sat     <= sat;
        if (sat && (sat_count != 16'hFFFF)) sat_count <= sat_count + 16'd1;
      end
    end
  end

endmodule
